// File: rtl/pair_swap_fifo.sv
// pair_swap_fifo: in-order buffer of (a, b) operand pairs with optional swap on entry
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     upstream handshake; in_a, in_b, swap_en sampled on push
//   out_valid/out_ready   downstream handshake; out_a, out_b show the head pair (0 when empty)
//   count                 number of stored pairs
//   swap_count            saturating number of accepted pairs that were swapped
module pair_swap_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_a,
  input  logic [WIDTH-1:0]           in_b,
  input  logic                       swap_en,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_a,
  output logic [WIDTH-1:0]           out_b,
  output logic [$clog2(DEPTH):0]     count,
  output logic [CNT_W-1:0]           swap_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [2*WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic push, pop;
  assign in_ready  = count != CW'(DEPTH);
  assign out_valid = count != '0;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign {out_a, out_b} = out_valid ? mem[rd_ptr] : '0;
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= swap_en ? {in_b, in_a} : {in_a, in_b};
  // Pointers wrap for free because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      swap_count <= '0;
    end else begin
      wr_ptr     <= wr_ptr + AW'(push);
      rd_ptr     <= rd_ptr + AW'(pop);
      count      <= count + CW'(push) - CW'(pop);
      swap_count <= (push && swap_en && !(&swap_count)) ? swap_count + 1'b1 : swap_count;
    end
  end
endmodule

// File: tb/tb_pair_swap_fifo.sv
// tb_pair_swap_fifo: directed self-checking bench for pair_swap_fifo
module tb_pair_swap_fifo;
  logic       clk = 0;
  logic       rst_n;
  logic       in_valid, in_ready, swap_en, out_valid, out_ready;
  logic [7:0] in_a, in_b, out_a, out_b;
  logic [2:0] count;
  logic [15:0] swap_count;
  logic       s_in_valid, s_in_ready, s_swap_en, s_out_valid, s_out_ready;
  logic [7:0] s_in_a, s_in_b, s_out_a, s_out_b;
  logic [2:0] s_count;
  logic [1:0] s_swap_count;
  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pair_swap_fifo dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .swap_en(swap_en), .out_valid(out_valid),
    .out_ready(out_ready), .out_a(out_a), .out_b(out_b), .count(count),
    .swap_count(swap_count)
  );

  pair_swap_fifo #(.CNT_W(2)) sat (
    .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_a(s_in_a), .in_b(s_in_b), .swap_en(s_swap_en), .out_valid(s_out_valid),
    .out_ready(s_out_ready), .out_a(s_out_a), .out_b(s_out_b), .count(s_count),
    .swap_count(s_swap_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 0; in_valid = 0; in_a = 0; in_b = 0; swap_en = 0; out_ready = 0;
    s_in_valid = 0; s_in_a = 0; s_in_b = 0; s_swap_en = 0; s_out_ready = 1;
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_count", count, 0);
    chk("rst_swap_count", swap_count, 0);
    chk("rst_out_a", out_a, 0);
    #10 rst_n = 1;
    #1 chk("rel_in_ready", in_ready, 1);

    // single swapped pair
    tick;
    in_valid = 1; in_a = 8'd123; in_b = 8'd200; swap_en = 1;
    tick;
    in_valid = 0; swap_en = 0;
    chk("single_out_valid", out_valid, 1);
    chk("single_out_a", out_a, 200);
    chk("single_out_b", out_b, 123);
    chk("single_swap_count", swap_count, 1);
    chk("single_count", count, 1);
    out_ready = 1;
    tick;
    out_ready = 0;
    chk("single_pop_valid", out_valid, 0);
    chk("single_pop_out_a", out_a, 0);

    // mid-cycle reset with a stored pair
    in_valid = 1; in_a = 5; in_b = 6;
    tick;
    in_valid = 0;
    chk("pre_rst_count", count, 1);
    #2 rst_n = 0;
    #1;
    chk("async_rst_count", count, 0);
    chk("async_rst_valid", out_valid, 0);
    chk("async_rst_out_a", out_a, 0);
    chk("async_rst_out_b", out_b, 0);
    chk("async_rst_swap_count", swap_count, 0);
    #1 rst_n = 1;
    tick;
    chk("post_rst_in_ready", in_ready, 1);

    // fill to full, fifth pair held upstream, then drain in order
    for (int i = 0; i < 4; i++) begin
      in_valid = 1; in_a = 8'(2*i+1); in_b = 8'(2*i+2);
      tick;
    end
    chk("full_count", count, 4);
    chk("full_in_ready", in_ready, 0);
    in_a = 9; in_b = 10;
    tick;
    chk("held_count", count, 4);
    out_ready = 1;
    for (int k = 0; k < 5; k++) begin
      chk("drain_out_a", out_a, 32'(2*k+1));
      chk("drain_out_b", out_b, 32'(2*k+2));
      tick;
      if (k == 1) in_valid = 0;
    end
    chk("drain_empty", out_valid, 0);

    // continuous stream through the wrap point
    for (int i = 0; i < 10; i++) begin
      in_valid = 1; in_a = 8'(16+i); in_b = 8'(32+i);
      tick;
      chk("stream_valid", out_valid, 1);
      chk("stream_out_a", out_a, 32'(16+i));
      chk("stream_out_b", out_b, 32'(32+i));
      chk("stream_count_le1", 32'(count <= 1), 1);
    end
    in_valid = 0;
    tick;
    chk("stream_empty", count, 0);

    // back-pressure
    out_ready = 0;
    in_valid = 1; in_a = 8'h55; in_b = 8'hAA;
    tick;
    in_a = 8'h11; in_b = 8'h22;
    tick;
    in_valid = 0;
    for (int i = 0; i < 5; i++) begin
      tick;
      chk("bp_hold_a", out_a, 8'h55);
      chk("bp_hold_b", out_b, 8'hAA);
    end
    out_ready = 1;
    tick;
    out_ready = 0;
    chk("bp_next_a", out_a, 8'h11);
    chk("bp_next_b", out_b, 8'h22);

    // saturating swap counter on the CNT_W=2 instance
    for (int i = 0; i < 5; i++) begin
      s_in_valid = 1; s_swap_en = 1; s_in_a = 8'(i); s_in_b = 8'(i+100);
      tick;
      chk("sat_swap_count", s_swap_count, (i < 3) ? 32'(i+1) : 32'd3);
    end
    s_in_valid = 0; s_swap_en = 0;

    // reset while count=2
    in_valid = 1; in_a = 1; in_b = 2;
    tick;
    in_valid = 0;
    chk("two_count", count, 2);
    #2 rst_n = 0;
    #1;
    chk("rst2_count", count, 0);
    chk("rst2_valid", out_valid, 0);
    #1 rst_n = 1;
    tick;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
